// File: rtl/elixirchip_es1_spu_op_acc.sv
// Accumulator op for the ES1 SPU stream datapath: clear/valid-gated running sum with sticky overflow.
// Define ELIXIRCHIP_ES1_SPU_OP_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.

module elixirchip_es1_spu_op_acc_chk #(
    parameter int    LATENCY = 1,
    parameter string DEVICE  = "RTL",
    parameter string DEBUG   = "false",
    parameter bit    ENABLE  = 1'b0
) (
    input  logic clk,
    input  logic cke,
    input  logic s_clear,
    input  logic s_valid
);

    // Parameter sanity and control-input X checks, active only in simulation builds
    always @(posedge clk) begin
        if (ENABLE) begin
            assert (LATENCY >= 1 && LATENCY <= 4);
            assert (DEVICE == "RTL" || DEVICE == "ULTRASCALE_PLUS");
            assert (DEBUG == "true" || DEBUG == "false");
            if (cke === 1'b1) begin
                assert (!$isunknown({s_clear, s_valid}));
            end
        end
    end

endmodule

module elixirchip_es1_spu_op_acc #(
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 8,
    parameter type   data_t     = logic [DATA_BITS-1:0],
    parameter data_t CLEAR_DATA = '0,
    parameter bit    SIGNED     = 1'b0,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_clear,
    input  logic                 s_valid,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_overflow
);

    // Out-of-range LATENCY is flagged by the checker; clamp here so elaboration still succeeds.
    localparam int STAGES = (LATENCY < 1) ? 1 : ((LATENCY > 4) ? 4 : LATENCY);
    localparam logic [DATA_BITS-1:0] CLEAR_VALUE = DATA_BITS'(CLEAR_DATA);

    logic [DATA_BITS-1:0] data_pipe_r [STAGES];
    logic                 ovf_pipe_r  [STAGES];

    logic [DATA_BITS-1:0] acc_r;
    logic                 ovf_r;
    logic [DATA_BITS:0]   sum_s;
    logic                 ovf_term_s;
    logic [DATA_BITS-1:0] add_result_s;
    logic [DATA_BITS-1:0] acc_next_s;
    logic                 ovf_next_s;

    function automatic logic calc_overflow(
        input logic [DATA_BITS-1:0] a,
        input logic [DATA_BITS-1:0] b,
        input logic [DATA_BITS:0]   sum
    );
        logic ovf_v;
        if (SIGNED) begin
            ovf_v = (a[DATA_BITS-1] == b[DATA_BITS-1]) && (sum[DATA_BITS-1] != a[DATA_BITS-1]);
        end else begin
            ovf_v = sum[DATA_BITS];
        end
        return ovf_v;
    endfunction

`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_SATURATE_EN
    // Overflow only happens with same-sign operands, so the accumulator sign picks the clamp direction.
    function automatic logic [DATA_BITS-1:0] sat_value(input logic a_msb);
        logic [DATA_BITS-1:0] top_bit_v;
        logic [DATA_BITS-1:0] val_v;
        top_bit_v                = '0;
        top_bit_v[DATA_BITS-1]   = 1'b1;
        if (SIGNED) begin
            val_v = a_msb ? top_bit_v : ~top_bit_v;
        end else begin
            val_v = '1;
        end
        return val_v;
    endfunction
`endif

    assign acc_r = data_pipe_r[0];
    assign ovf_r = ovf_pipe_r[0];

    // Next accumulator value and sticky flag; clear outranks valid
    always_comb begin
        sum_s      = {1'b0, acc_r} + {1'b0, s_data};
        ovf_term_s = calc_overflow(acc_r, s_data, sum_s);
`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_SATURATE_EN
        if (ovf_term_s) begin
            add_result_s = sat_value(acc_r[DATA_BITS-1]);
        end else begin
            add_result_s = sum_s[DATA_BITS-1:0];
        end
`else
        add_result_s = sum_s[DATA_BITS-1:0];
`endif
        if (s_clear) begin
            acc_next_s = CLEAR_VALUE;
            ovf_next_s = 1'b0;
        end else if (s_valid) begin
            acc_next_s = add_result_s;
            ovf_next_s = ovf_r | ovf_term_s;
        end else begin
            acc_next_s = acc_r;
            ovf_next_s = ovf_r;
        end
    end

    // Stage 0 is the accumulator; later stages are pure delay, all frozen when cke is low
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                data_pipe_r[i] <= CLEAR_VALUE;
                ovf_pipe_r[i]  <= 1'b0;
            end
        end else if (cke) begin
            data_pipe_r[0] <= acc_next_s;
            ovf_pipe_r[0]  <= ovf_next_s;
            for (int i = 1; i < STAGES; i++) begin
                data_pipe_r[i] <= data_pipe_r[i-1];
                ovf_pipe_r[i]  <= ovf_pipe_r[i-1];
            end
        end
    end

    assign m_data     = data_pipe_r[STAGES-1];
    assign m_overflow = ovf_pipe_r[STAGES-1];

    elixirchip_es1_spu_op_acc_chk #(
        .LATENCY (LATENCY),
        .DEVICE  (DEVICE),
        .DEBUG   (DEBUG),
        .ENABLE  (SIMULATION == "true")
    ) u_chk (
        .clk     (clk),
        .cke     (cke),
        .s_clear (s_clear),
        .s_valid (s_valid)
    );

endmodule
